// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch PC unit: predecode fields and FSM encodings.
// Build option STATIC_BTFN_EN selects backward-taken/forward-not-taken.
package fetch_pc_unit_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [3:0] BRANCH_OPCODE = 4'b1111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int OFFSET_MSB = 20;
  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_WIDTH = OFFSET_MSB - OFFSET_LSB + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  function automatic logic [31:0] sext_offset(
    input logic [INSTR_WIDTH-1:0] word
  );
    return {{(32 - OFFSET_WIDTH){word[OFFSET_MSB]}},
            word[OFFSET_MSB:OFFSET_LSB]};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Single-entry valid/ready handoff from fetch to decode.
// Fetch drives the master side, decode the slave side.
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic [INSTR_WIDTH-1:0] instruction_o;
  logic [31:0]            instruction_pc_o;
  logic                   predicted_taken_o;
  logic                   instruction_valid_o;
  logic                   decode_ready_i;

  modport master (
    output instruction_o,
    output instruction_pc_o,
    output predicted_taken_o,
    output instruction_valid_o,
    input  decode_ready_i
  );

  modport slave (
    input  instruction_o,
    input  instruction_pc_o,
    input  predicted_taken_o,
    input  instruction_valid_o,
    output decode_ready_i
  );

endinterface

// File: rtl/fetch_pc_unit_branch_predecoder.sv
// Combinational predecode of a fetched word: branch detect,
// offset direction and taken target.
module branch_predecoder
  import fetch_pc_unit_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] word,
  input  logic [31:0]            pc,
  output logic                   is_branch,
  output logic                   is_backward,
  output logic [31:0]            target
);

  assign is_branch =
    (word[OPCODE_MSB:OPCODE_LSB] == BRANCH_OPCODE);

  assign is_backward = is_branch & word[OFFSET_MSB];

  assign target = pc + 32'd4 + sext_offset(word);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, single-outstanding imem read, predecode.
// STATIC_BTFN_EN: predict backward-taken, ignore branch_predicted_i.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  output logic [31:0]            current_pc_o,
  input  logic                   branch_predicted_i,
  output logic                   is_backward_branch_o,
  output logic [31:0]            imem_address_o,
  output logic                   imem_read_o,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  input  logic                   imem_valid_i,
  fetch_pc_unit_if.master        dec,
  input  logic                   mispredict_i,
  input  logic [31:0]            mispredict_target_i
);

  logic [1:0]             state;
  logic [31:0]            pc;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [31:0]            instr_pc_q;
  logic                   taken_q;
  logic                   valid_q;

  logic                   is_branch;
  logic                   is_backward;
  logic [31:0]            branch_target;
  logic                   predict;
  logic                   taken;
  logic [31:0]            next_pc;
  logic                   transfer;

  branch_predecoder u_predec (
    .word        (imem_data_i),
    .pc          (pc),
    .is_branch   (is_branch),
    .is_backward (is_backward),
    .target      (branch_target)
  );

`ifdef STATIC_BTFN_EN
  logic unused_branch_predicted;
  assign unused_branch_predicted = branch_predicted_i;
  assign predict = is_backward;
`else
  assign predict = branch_predicted_i;
`endif

  assign taken    = is_branch & predict;
  assign next_pc  = taken ? branch_target : pc + 32'd4;
  assign transfer = valid_q & dec.decode_ready_i;

  // A request may only go out when the output slot is free or draining.
  assign imem_read_o = (state == ST_REQ)
                     & (~valid_q | dec.decode_ready_i)
                     & ~mispredict_i;

  assign current_pc_o         = pc;
  assign imem_address_o       = pc;
  assign is_backward_branch_o = is_backward;

  assign dec.instruction_o       = instr_q;
  assign dec.instruction_pc_o    = instr_pc_q;
  assign dec.predicted_taken_o   = taken_q;
  assign dec.instruction_valid_o = valid_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      pc         <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      taken_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else if (mispredict_i) begin
      pc      <= mispredict_target_i;
      valid_q <= 1'b0;
      unique case (state)
        ST_WAIT:  state <= imem_valid_i ? ST_REQ : ST_FLUSH;
        ST_FLUSH: state <= ST_FLUSH;
        default:  state <= ST_REQ;
      endcase
    end else begin
      if (transfer) valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imem_read_o) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid_i) begin
            instr_q    <= imem_data_i;
            instr_pc_q <= pc;
            taken_q    <= taken;
            valid_q    <= 1'b1;
            pc         <= next_pc;
            state      <= ST_REQ;
          end
        end
        ST_FLUSH: begin
          if (imem_valid_i) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: table of branch cases plus
// hand-written stall, redirect and reset sequences, with a scoreboard.
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] current_pc_o;
  logic        branch_predicted_i = 1'b0;
  logic        is_backward_branch_o;
  logic [31:0] imem_address_o;
  logic        imem_read_o;
  logic [31:0] imem_data_i = '0;
  logic        imem_valid_i = 1'b0;
  logic        mispredict_i = 1'b0;
  logic [31:0] mispredict_target_i = '0;

  fetch_pc_unit_if ifc ();

  fetch_pc_unit #(.RESET_VECTOR(RV)) dut (
    .clock_i              (clk),
    .reset_i              (reset_i),
    .current_pc_o         (current_pc_o),
    .branch_predicted_i   (branch_predicted_i),
    .is_backward_branch_o (is_backward_branch_o),
    .imem_address_o       (imem_address_o),
    .imem_read_o          (imem_read_o),
    .imem_data_i          (imem_data_i),
    .imem_valid_i         (imem_valid_i),
    .dec                  (ifc),
    .mispredict_i         (mispredict_i),
    .mispredict_target_i  (mispredict_target_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } sb_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        bp;
    logic [31:0] next;
    logic        pt;
    logic        bw;
  } vec_t;

  sb_t         sb[$];
  logic [31:0] mem[logic [31:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int n_reads = 0;
  int n_xfer = 0;
  int cyc = 0;
  int cnt = 0;
  int k_lat = 1;
  int last_read_cyc = 0;

  logic        rst_d = 1'b1;
  logic        ready_d = 1'b1;
  logic        misp_d = 1'b0;
  logic [31:0] tgt_d = '0;
  logic        bp_d = 1'b0;
  logic [31:0] exp_pc = RV;
  logic [31:0] paddr = '0;
  logic        flushing = 1'b0;
  logic [31:0] last_read = '0;
  logic [31:0] last_xfer_pc = '0;
  logic        last_xfer_pt = 1'b0;
  logic        last_bw = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : NOP;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic        resp;
    logic [31:0] w;
    logic [31:0] sx;
    logic        pr;
    logic        tk;
    sb_t         e;
    @(negedge clk);
    cyc++;
    resp = 1'b0;
    if (cnt > 0) begin
      cnt--;
      resp = (cnt == 0);
    end
    reset_i             = rst_d;
    imem_valid_i        = resp;
    imem_data_i         = resp ? word_at(paddr) : $urandom;
    ifc.decode_ready_i  = ready_d;
    mispredict_i        = misp_d;
    mispredict_target_i = tgt_d;
    branch_predicted_i  = bp_d;
    #1;
    if (rst_d) begin
      sb.delete();
      exp_pc   = RV;
      flushing = (cnt > 0);
      return;
    end
    if (misp_d) begin
      chk("misp_read_suppressed", {31'b0, imem_read_o}, 32'd0);
      sb.delete();
      exp_pc   = tgt_d;
      flushing = (cnt > 0);
      return;
    end
    if (ifc.instruction_valid_o && ready_d) begin
      n_xfer++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got pc %h expected no transfer",
                 ifc.instruction_pc_o);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", ifc.instruction_pc_o, e.pc);
        chk("xfer_instr", ifc.instruction_o, e.instr);
        chk("xfer_pt", {31'b0, ifc.predicted_taken_o}, {31'b0, e.pt});
        last_xfer_pc = ifc.instruction_pc_o;
        last_xfer_pt = ifc.predicted_taken_o;
      end
    end
    if (resp) begin
      if (flushing) begin
        flushing = 1'b0;
      end else begin
        w  = imem_data_i;
        sx = {{11{w[20]}}, w[20:0]};
`ifdef STATIC_BTFN_EN
        pr = w[20];
`else
        pr = bp_d;
`endif
        tk = (w[31:28] == 4'hF) && pr;
        e.pc    = paddr;
        e.instr = w;
        e.pt    = tk;
        sb.push_back(e);
        exp_pc  = tk ? paddr + 32'd4 + sx : paddr + 32'd4;
        last_bw = is_backward_branch_o;
      end
    end
    if (imem_read_o) begin
      if (cnt > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL overlap: got read with %0d cycles pending expected 0",
                 cnt);
      end
      chk("read_addr", imem_address_o, exp_pc);
      cnt           = k_lat;
      paddr         = exp_pc;
      last_read     = imem_address_o;
      last_read_cyc = cyc;
      n_reads++;
    end
  endtask

  task automatic wait_read(input string nm);
    int s;
    int b;
    s = n_reads;
    b = 0;
    while (n_reads == s && b < 60) begin
      step();
      b++;
    end
    if (n_reads == s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no read expected a read", nm);
    end
  endtask

  vec_t tbl[6];

  initial begin
    int c1;
    int c2;
    int c3;
    int i;
    int r0;
    int x0;

    tbl[0] = '{32'h200, 32'hF000_0010, 1'b1, 32'h214, 1'b1, 1'b0};
    tbl[1] = '{32'h200, 32'hF000_0010, 1'b0, 32'h204, 1'b0, 1'b0};
    tbl[2] = '{32'h300, 32'hF01F_FFF0, 1'b1, 32'h2F4, 1'b1, 1'b1};
    tbl[3] = '{32'h300, 32'hF01F_FFF0, 1'b0, 32'h304, 1'b0, 1'b1};
    tbl[4] = '{32'h200, NOP, 1'b1, 32'h204, 1'b0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFC, 32'hF000_0008, 1'b1, 32'h8, 1'b1, 1'b0};
`ifdef STATIC_BTFN_EN
    tbl[0].next = 32'h204;
    tbl[0].pt   = 1'b0;
    tbl[3].next = 32'h2F4;
    tbl[3].pt   = 1'b1;
    tbl[5].next = 32'h0;
    tbl[5].pt   = 1'b0;
`endif
    ifc.decode_ready_i = 1'b1;

    // reset values
    repeat (3) step();
    @(posedge clk);
    #1;
    chk("rst_pc", current_pc_o, RV);
    chk("rst_read", {31'b0, imem_read_o}, 32'd0);
    chk("rst_valid", {31'b0, ifc.instruction_valid_o}, 32'd0);
    chk("rst_pt", {31'b0, ifc.predicted_taken_o}, 32'd0);
    chk("rst_instr", ifc.instruction_o, 32'd0);
    chk("rst_ipc", ifc.instruction_pc_o, 32'd0);

    // sequential fetch, 1-cycle memory
    rst_d = 1'b0;
    i = 0;
    while (n_reads == 0 && i < 10) begin
      step();
      i++;
    end
    chk("first_read_cycle", i, 2);
    chk("first_read_addr", last_read, RV);
    c1 = last_read_cyc;
    wait_read("seq2");
    chk("seq2_addr", last_read, RV + 4);
    c2 = last_read_cyc;
    wait_read("seq3");
    chk("seq3_addr", last_read, RV + 8);
    c3 = last_read_cyc;
    chk("spacing_a", c2 - c1, 2);
    chk("spacing_b", c3 - c2, 2);
    repeat (2) step();
    chk("seq_xfers", (n_xfer >= 3) ? 32'd1 : 32'd0, 32'd1);

    // branch table
    for (int t = 0; t < 6; t++) begin
      mem[tbl[t].pc] = tbl[t].word;
      bp_d   = tbl[t].bp;
      misp_d = 1'b1;
      tgt_d  = tbl[t].pc;
      step();
      misp_d = 1'b0;
      wait_read("tbl_first");
      chk("tbl_first_addr", last_read, tbl[t].pc);
      wait_read("tbl_next");
      chk("tbl_next_addr", last_read, tbl[t].next);
      chk("tbl_pt", {31'b0, last_xfer_pt}, {31'b0, tbl[t].pt});
      chk("tbl_bw", {31'b0, last_bw}, {31'b0, tbl[t].bw});
    end
    bp_d = 1'b0;

    // decode stall for 5 cycles
    wait_read("stall_pre");
    ready_d = 1'b0;
    step();
    r0 = n_reads;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("stall_valid", {31'b0, ifc.instruction_valid_o}, 32'd1);
      chk("stall_instr", ifc.instruction_o, sb[0].instr);
      chk("stall_ipc", ifc.instruction_pc_o, sb[0].pc);
      chk("stall_no_read", n_reads, r0);
    end
    ready_d = 1'b1;
    x0 = n_xfer;
    step();
    chk("stall_release_read", n_reads, r0 + 1);
    chk("stall_release_xfer", n_xfer, x0 + 1);

    // mispredict while waiting on a 3-cycle memory
    k_lat = 3;
    wait_read("misp_wait_pre");
    step();
    misp_d = 1'b1;
    tgt_d  = 32'h400;
    step();
    misp_d = 1'b0;
    step();
    r0 = n_reads;
    step();
    chk("flush_valid", {31'b0, ifc.instruction_valid_o}, 32'd0);
    chk("flush_read", n_reads, r0 + 1);
    chk("flush_addr", last_read, 32'h400);
    repeat (4) step();
    chk("flush_xfer_pc", last_xfer_pc, 32'h400);

    // mispredict in the same cycle as the response
    wait_read("misp_resp_pre");
    step();
    step();
    misp_d = 1'b1;
    tgt_d  = 32'h600;
    step();
    misp_d = 1'b0;
    r0 = n_reads;
    step();
    chk("same_valid", {31'b0, ifc.instruction_valid_o}, 32'd0);
    chk("same_read", n_reads, r0 + 1);
    chk("same_addr", last_read, 32'h600);
    repeat (4) step();
    chk("same_xfer_pc", last_xfer_pc, 32'h600);

    // reset while a request is outstanding
    wait_read("rst_mid_pre");
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    step();
    chk("rst_mid_idle_read", {31'b0, imem_read_o}, 32'd0);
    r0 = n_reads;
    step();
    chk("rst_mid_read", n_reads, r0 + 1);
    chk("rst_mid_addr", last_read, RV);
    repeat (4) step();
    chk("rst_mid_xfer_pc", last_xfer_pc, RV);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
